// File: rtl/jtag_debug_cmd_sysclk_queue.sv
// System-clock side of the debug JTAG bridge.
// The update-DR / update-IR level strobes arrive from the TCK domain and are
// synchronised here. Each update-DR edge captures {ir_in, sr} into a small
// command queue. Each command the consumer pops produces a one-cycle decoded
// take_action / take_no_action pulse, and jdo carries the popped data word.
module jtag_debug_cmd_sysclk_queue #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACTION_BIT  = 37,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DR_WIDTH-1:0]                sr,
  input  logic [IR_WIDTH-1:0]                ir_in,
  input  logic                               vs_udr,
  input  logic                               vs_uir,
  input  logic                               cmd_ready,
  output logic                               cmd_valid,
  output logic [IR_WIDTH-1:0]                cmd_ir,
  output logic [DR_WIDTH-1:0]                jdo,
  output logic [(1<<IR_WIDTH)-1:0]           take_action,
  output logic [(1<<IR_WIDTH)-1:0]           take_no_action,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int CH  = 1 << IR_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = IR_WIDTH + DR_WIDTH;
  localparam int TOP = SYNC_STAGES - 1;

  // One-hot decode of a channel number.
  function automatic logic [CH-1:0] ir_onehot(input logic [IR_WIDTH-1:0] ir);
    logic [CH-1:0] v;
    v     = {CH{1'b0}};
    v[ir] = 1'b1;
    return v;
  endfunction

  // Synchroniser, edge-detect and arming state.
  logic [SYNC_STAGES-1:0] udr_sync_r;
  logic [SYNC_STAGES-1:0] uir_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   udr_prev_r;
  logic                   uir_prev_r;
  logic                   udr_arm_r;
  logic                   uir_arm_r;

  // Queue state.
  logic [EW-1:0]          mem_r [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [LW-1:0]          level_r;
  logic                   cmd_valid_r;

  // Output registers.
  logic [DR_WIDTH-1:0]    jdo_r;
  logic [CH-1:0]          act_r;
  logic [CH-1:0]          noact_r;
  logic                   overflow_r;

  // Combinational control.
  logic                   udr_edge_s;
  logic                   uir_edge_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   full_s;
  logic                   ovf_set_s;
  logic [LW-1:0]          level_next_s;
  logic [EW-1:0]          head_s;
  logic [DR_WIDTH-1:0]    head_dr_s;
  logic [IR_WIDTH-1:0]    head_ir_s;

  assign head_s    = mem_r[rd_ptr_r[AW-1:0]];
  assign head_dr_s = head_s[DR_WIDTH-1:0];
  assign head_ir_s = head_s[EW-1:DR_WIDTH];

  // Shift both strobes through their synchroniser chains.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_r <= {SYNC_STAGES{1'b0}};
      uir_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
      uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
    end
  end

  // Track when the synchroniser chains hold genuine post-reset samples.
  // Without this, the zeros that reset loads into the chains would look
  // like a low strobe. A strobe held high through reset would then arm
  // the detector and raise a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_r <= {SYNC_STAGES{1'b0}};
    end else begin
      fill_r <= {fill_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Edge-detect history and arm flags (an arm flag sets on a real low sample).
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_prev_r <= 1'b0;
      uir_prev_r <= 1'b0;
      udr_arm_r  <= 1'b0;
      uir_arm_r  <= 1'b0;
    end else begin
      udr_prev_r <= udr_sync_r[TOP];
      uir_prev_r <= uir_sync_r[TOP];
      udr_arm_r  <= udr_arm_r | (fill_r[TOP] & ~udr_sync_r[TOP]);
      uir_arm_r  <= uir_arm_r | (fill_r[TOP] & ~uir_sync_r[TOP]);
    end
  end

  // Edge detection, push/pop arbitration and next queue level.
  always_comb begin
    udr_edge_s   = udr_arm_r & udr_sync_r[TOP] & ~udr_prev_r;
    uir_edge_s   = uir_arm_r & uir_sync_r[TOP] & ~uir_prev_r;
    pop_s        = cmd_valid_r & cmd_ready;
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    push_s       = 1'b0;
    ovf_set_s    = 1'b0;
    level_next_s = level_r;
    // A full queue still accepts a push when a pop frees the head slot in
    // the same cycle.
    if (udr_edge_s) begin
      if (full_s && !pop_s) begin
        ovf_set_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    if (push_s && !pop_s) begin
      level_next_s = level_r + {{(LW-1){1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      level_next_s = level_r - {{(LW-1){1'b0}}, 1'b1};
    end else begin
      level_next_s = level_r;
    end
  end

  // Queue storage write. Entries need no reset because the pointers
  // define which entries are live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {ir_in, sr};
    end
  end

  // Queue pointers, level and the non-empty flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      level_r     <= {LW{1'b0}};
      cmd_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      level_r     <= level_next_s;
      cmd_valid_r <= (level_next_s != {LW{1'b0}});
    end
  end

  // Register the popped data and the one-cycle decoded action pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo_r   <= {DR_WIDTH{1'b0}};
      act_r   <= {CH{1'b0}};
      noact_r <= {CH{1'b0}};
    end else if (pop_s) begin
      jdo_r <= head_dr_s;
      if (head_dr_s[ACTION_BIT]) begin
        act_r   <= ir_onehot(head_ir_s);
        noact_r <= {CH{1'b0}};
      end else begin
        act_r   <= {CH{1'b0}};
        noact_r <= ir_onehot(head_ir_s);
      end
    end else begin
      act_r   <= {CH{1'b0}};
      noact_r <= {CH{1'b0}};
    end
  end

  // Sticky overflow flag. A drop in the same cycle as an update-IR edge
  // leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (uir_edge_s) begin
      overflow_r <= 1'b0;
    end
  end

  assign cmd_valid      = cmd_valid_r;
  assign cmd_ir         = head_ir_s;
  assign jdo            = jdo_r;
  assign take_action    = act_r;
  assign take_no_action = noact_r;
  assign overflow       = overflow_r;
  assign fifo_level     = level_r;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk_queue.sv
// Directed bench for jtag_debug_cmd_sysclk_queue with a scoreboard of
// expected commands, checked whenever the DUT pops an entry.
module tb_jtag_debug_cmd_sysclk_queue;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] dr;
  } cmd_t;

  logic        clk;
  logic        reset;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_udr;
  logic        vs_uir;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        overflow;
  logic [2:0]  fifo_level;

  int   tests  = 0;
  int   failed = 0;
  cmd_t sb[$];
  logic pop_pending = 1'b0;
  bit   mon_en = 1'b0;

  jtag_debug_cmd_sysclk_queue dut (
    .clk            (clk),
    .reset          (reset),
    .sr             (sr),
    .ir_in          (ir_in),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Note whether the coming edge pops a command (values before the edge).
  always @(posedge clk) begin
    pop_pending <= (cmd_valid === 1'b1) && (cmd_ready === 1'b1) && (reset === 1'b0);
  end

  // Scoreboard: every pop must match the oldest expected command.
  always @(negedge clk) begin
    cmd_t       e;
    logic [3:0] exp_act;
    logic [3:0] exp_noact;
    if (mon_en) begin
      if (pop_pending) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e         = sb.pop_front();
          exp_act   = e.dr[37] ? (4'b0001 << e.ir) : 4'b0000;
          exp_noact = e.dr[37] ? 4'b0000 : (4'b0001 << e.ir);
          check("pop_jdo", {26'd0, jdo}, {26'd0, e.dr});
          check("pop_act", {60'd0, take_action}, {60'd0, exp_act});
          check("pop_noact", {60'd0, take_no_action}, {60'd0, exp_noact});
        end
      end else begin
        check("idle_act", {60'd0, take_action}, 64'd0);
        check("idle_noact", {60'd0, take_no_action}, 64'd0);
      end
      if (cmd_valid === 1'b1 && sb.size() != 0) begin
        check("cmd_ir", {62'd0, cmd_ir}, {62'd0, sb[0].ir});
      end
    end
  end

  task automatic udr_pulse(input logic [1:0] ir, input logic [37:0] d, input bit accept);
    @(negedge clk);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    if (accept) sb.push_back({ir, d});
    repeat (SYNC + 3) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (SYNC + 3) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    @(negedge clk);
    cmd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 check("drain_pulse", {63'd0, |(take_action | take_no_action)}, 64'd1);
    end
    @(negedge clk);
    cmd_ready = 1'b0;
    @(posedge clk);
    #1 check("drain_level", {61'd0, fifo_level}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; sr = 38'd0; ir_in = 2'd0;
    vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, cmd_valid}, 64'd0);
    check("rst_jdo", {26'd0, jdo}, 64'd0);
    check("rst_act", {60'd0, take_action}, 64'd0);
    check("rst_noact", {60'd0, take_no_action}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_level", {61'd0, fifo_level}, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);

    // Action command on channel 1, latency of three edges
    @(negedge clk);
    cmd_ready = 1'b1;
    ir_in = 2'b01;
    sr = {1'b1, 5'd0, 32'hDEADBEEF};
    vs_udr = 1'b1;
    sb.push_back({2'b01, 1'b1, 5'd0, 32'hDEADBEEF});
    @(posedge clk); #1 check("lat_e0", {63'd0, cmd_valid}, 64'd0);
    @(posedge clk); #1 check("lat_e1", {63'd0, cmd_valid}, 64'd0);
    @(posedge clk); #1 check("lat_e2", {63'd0, cmd_valid}, 64'd1);
    @(posedge clk); #1;
    check("t1_act", {60'd0, take_action}, 64'h2);
    check("t1_jdo", {32'd0, jdo[31:0]}, 64'hDEADBEEF);
    check("t1_level", {61'd0, fifo_level}, 64'd0);
    @(posedge clk); #1;
    check("t1_act_off", {60'd0, take_action}, 64'd0);
    check("t1_jdo_hold", {32'd0, jdo[31:0]}, 64'hDEADBEEF);
    vs_udr = 1'b0;
    repeat (5) @(posedge clk);

    // No-action command on channel 3
    udr_pulse(2'b11, {1'b0, 5'd0, 32'h12345678}, 1'b1);
    cmd_ready = 1'b0;

    // Five updates with the consumer stalled: the fifth is dropped
    udr_pulse(2'b00, {1'b1, 5'd1, 32'hA0000001}, 1'b1);
    udr_pulse(2'b01, {1'b0, 5'd2, 32'hA0000002}, 1'b1);
    udr_pulse(2'b10, {1'b1, 5'd3, 32'hA0000003}, 1'b1);
    udr_pulse(2'b11, {1'b0, 5'd4, 32'hA0000004}, 1'b1);
    check("fill4_ovf", {63'd0, overflow}, 64'd0);
    udr_pulse(2'b10, {1'b1, 5'd5, 32'hA0000005}, 1'b0);
    check("full_level", {61'd0, fifo_level}, 64'd4);
    check("full_ovf", {63'd0, overflow}, 64'd1);

    // Update-IR clears overflow and leaves the queue alone
    @(negedge clk);
    vs_uir = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1 check("uir_clear", {63'd0, overflow}, 64'd0);
    check("uir_level", {61'd0, fifo_level}, 64'd4);
    vs_uir = 1'b0;
    repeat (5) @(posedge clk);

    // Push while full in the same cycle as a pop: accepted, no overflow
    @(negedge clk);
    ir_in = 2'b10;
    sr = {1'b0, 5'd6, 32'hB0000006};
    vs_udr = 1'b1;
    sb.push_back({2'b10, 1'b0, 5'd6, 32'hB0000006});
    @(posedge clk);
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    check("same_level", {61'd0, fifo_level}, 64'd4);
    check("same_ovf", {63'd0, overflow}, 64'd0);
    repeat (3) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (5) @(posedge clk);
    drain(4);

    // Strobe held high through reset: no push until it drops and rises
    @(negedge clk);
    vs_udr = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("held_level", {61'd0, fifo_level}, 64'd0);
    check("held_valid", {63'd0, cmd_valid}, 64'd0);
    @(negedge clk);
    vs_udr = 1'b0;
    repeat (5) @(posedge clk);
    udr_pulse(2'b01, {1'b1, 5'd7, 32'hC0000007}, 1'b1);
    check("rearm_level", {61'd0, fifo_level}, 64'd1);
    drain(1);

    // Reset in the middle of a drain discards everything
    udr_pulse(2'b00, {1'b1, 5'd8, 32'hD0000008}, 1'b1);
    udr_pulse(2'b01, {1'b0, 5'd9, 32'hD0000009}, 1'b1);
    udr_pulse(2'b10, {1'b1, 5'd10, 32'hD000000A}, 1'b1);
    @(negedge clk);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_valid", {63'd0, cmd_valid}, 64'd0);
    check("mid_jdo", {26'd0, jdo}, 64'd0);
    check("mid_act", {60'd0, take_action}, 64'd0);
    check("mid_noact", {60'd0, take_no_action}, 64'd0);
    check("mid_ovf", {63'd0, overflow}, 64'd0);
    check("mid_level", {61'd0, fifo_level}, 64'd0);
    sb.delete();
    reset = 1'b0;
    cmd_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
